// File: rtl/iq_integrate_dump_pkg.sv
// Shared definitions for the I/Q integrate-and-dump decimator: default widths,
// the derived accumulator and exponent widths, and the two-state control enum.
package iq_integrate_dump_pkg;

  localparam int BIT_WIDTH_DEF    = 16;
  localparam int DEC_LOG2_MAX_DEF = 8;

  // Accumulator holds the sum of up to 2^DEC_LOG2_MAX samples without wrapping.
  localparam int ACC_WIDTH = BIT_WIDTH_DEF + DEC_LOG2_MAX_DEF;
  localparam int DEC_W     = $clog2(DEC_LOG2_MAX_DEF + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Width of the dec_log2 field for an arbitrary DEC_LOG2_MAX override.
  function automatic int dec_width(input int dec_log2_max);
    return (dec_log2_max < 1) ? 1 : $clog2(dec_log2_max + 1);
  endfunction

  function automatic int acc_width(input int bit_width, input int dec_log2_max);
    return bit_width + dec_log2_max;
  endfunction

endpackage : iq_integrate_dump_pkg

// File: rtl/iq_dump_channel.sv
// One real-valued integrate-and-dump lane: accumulator, averaging shift and
// result register. Sequencing (window count, handshake) is supplied by the top.
module iq_dump_channel
  import iq_integrate_dump_pkg::*;
#(
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int DEC_LOG2_MAX = DEC_LOG2_MAX_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear_i,
  input  logic                                   accept_i,
  input  logic                                   dump_i,
  input  logic                                   load_i,
  input  logic [dec_width(DEC_LOG2_MAX)-1:0]     k_i,
  input  logic signed [BIT_WIDTH-1:0]            sample_i,
  output logic signed [BIT_WIDTH-1:0]            result_o
);

  localparam int AW = acc_width(BIT_WIDTH, DEC_LOG2_MAX);

  logic signed [AW-1:0]        acc_q, acc_d;
  logic signed [AW-1:0]        sum;
  logic signed [AW-1:0]        shifted;
  logic signed [BIT_WIDTH-1:0] res_q, res_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    sum     = acc_q + AW'(sample_i);
    shifted = sum >>> k_i;
    acc_d   = acc_q;
    res_d   = res_q;

    if (clear_i) begin
      acc_d = '0;
    end else if (accept_i) begin
      acc_d = dump_i ? '0 : sum;
    end

    // The full-width sum of the closing sample feeds the shift, so the window
    // completes on the same edge without an extra accumulate cycle.
    if (load_i) begin
      res_d = shifted[BIT_WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule : iq_dump_channel

// File: rtl/iq_integrate_dump.sv
// Decimating I/Q integrate-and-dump: averages 2^k complex samples per output,
// with a valid/ready output stage and a sticky overrun flag for dropped results.
module iq_integrate_dump
  import iq_integrate_dump_pkg::*;
#(
  parameter int BIT_WIDTH    = BIT_WIDTH_DEF,
  parameter int DEC_LOG2_MAX = DEC_LOG2_MAX_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               run,
  input  logic [dec_width(DEC_LOG2_MAX)-1:0] dec_log2,
  input  logic                               in_valid,
  input  logic signed [BIT_WIDTH-1:0]        i_in,
  input  logic signed [BIT_WIDTH-1:0]        q_in,
  output logic signed [BIT_WIDTH-1:0]        i_out,
  output logic signed [BIT_WIDTH-1:0]        q_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               overrun,
  input  logic                               clear_overrun
);

  localparam int KW = dec_width(DEC_LOG2_MAX);
  localparam int CW = (DEC_LOG2_MAX < 1) ? 1 : DEC_LOG2_MAX;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           overrun_q, overrun_d;

  logic [KW-1:0]  k_clamped;
  logic [CW:0]    win_len;
  logic [CW-1:0]  cnt_last;
  logic           start, stop, clear_acc;
  logic           accept, dump, load, drop;

  always_comb begin
    k_clamped = (dec_log2 > KW'(DEC_LOG2_MAX)) ? KW'(DEC_LOG2_MAX) : dec_log2;
    win_len   = (CW + 1)'(1) << k_q;
    cnt_last  = CW'(win_len - (CW + 1)'(1));
  end

  // A sample only counts while run is held; dropping run discards the window.
  assign start     = (state_q == IDLE) && run;
  assign stop      = (state_q == ACCUM) && !run;
  assign clear_acc = start || stop;
  assign accept    = (state_q == ACCUM) && run && in_valid;
  assign dump      = accept && (cnt_q == cnt_last);
  assign load      = dump && (!out_valid_q || out_ready);
  assign drop      = dump && out_valid_q && !out_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = ACCUM;
          k_d     = k_clamped;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (dump) begin
            cnt_d = '0;
            k_d   = k_clamped;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A coincident dump keeps out_valid high (back-to-back); set beats clear.
  always_comb begin
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  iq_dump_channel #(
    .BIT_WIDTH    (BIT_WIDTH),
    .DEC_LOG2_MAX (DEC_LOG2_MAX)
  ) u_chan_i (
    .clk      (clock),
    .rst_n    (reset),
    .clear_i  (clear_acc),
    .accept_i (accept),
    .dump_i   (dump),
    .load_i   (load),
    .k_i      (k_q),
    .sample_i (i_in),
    .result_o (i_out)
  );

  iq_dump_channel #(
    .BIT_WIDTH    (BIT_WIDTH),
    .DEC_LOG2_MAX (DEC_LOG2_MAX)
  ) u_chan_q (
    .clk      (clock),
    .rst_n    (reset),
    .clear_i  (clear_acc),
    .accept_i (accept),
    .dump_i   (dump),
    .load_i   (load),
    .k_i      (k_q),
    .sample_i (q_in),
    .result_o (q_out)
  );

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule : iq_integrate_dump

// File: tb/tb_iq_integrate_dump.sv
// Directed bench for iq_integrate_dump: stimulus pushes hand-computed results
// into a scoreboard queue, a negedge monitor pops them on each output transfer.
module tb_iq_integrate_dump;

  logic               clock;
  logic               reset;
  logic               run;
  logic [3:0]         dec_log2;
  logic               in_valid;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               clear_overrun;

  typedef struct {
    int i;
    int q;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  iq_integrate_dump #(
    .BIT_WIDTH    (16),
    .DEC_LOG2_MAX (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .dec_log2      (dec_log2),
    .in_valid      (in_valid),
    .i_in          (i_in),
    .q_in          (q_in),
    .i_out         (i_out),
    .q_out         (q_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int i, input int q);
    i_in     = 16'(i);
    q_in     = 16'(q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input int i, input int q);
    exp_t e;
    e.i = i;
    e.q = q;
    sb.push_back(e);
  endtask

  // Monitor: a transfer happens on the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got i=%0d q=%0d expected no output", i_out, q_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_i_out", i_out, e.i);
        check("sb_q_out", q_out, e.q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; run = 1'b0; dec_log2 = '0; in_valid = 1'b0;
    i_in = '0; q_in = '0; out_ready = 1'b0; clear_overrun = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_i_out", i_out, 0);
    check("rst_q_out", q_out, 0);
    reset = 1'b1;
    tick();

    // k=2 constant input, 4 windows
    out_ready = 1'b1; dec_log2 = 4'd2; run = 1'b1;
    tick();
    for (int n = 1; n <= 16; n++) begin
      if (n % 4 == 0) expect_out(100, -100);
      send(100, -100);
      if (n == 3) check("k2_valid_before_4th", out_valid, 0);
      if (n == 4) check("k2_valid_after_4th", out_valid, 1);
      if (n == 5) check("k2_valid_after_xfer", out_valid, 0);
    end
    run = 1'b0;
    tick(); tick();

    // k=0 registered pass-through
    dec_log2 = 4'd0; run = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin
      expect_out(n, -n);
      send(n, -n);
      if (n >= 1 && n <= 4) check("k0_valid_held", out_valid, 1);
    end
    run = 1'b0;
    tick(); tick();

    // k=8 full-scale, then k=1 floor of negative average
    dec_log2 = 4'd8; run = 1'b1;
    tick();
    for (int n = 1; n <= 256; n++) begin
      if (n == 256) expect_out(-32768, 32767);
      send(-32768, 32767);
    end
    run = 1'b0;
    tick();
    dec_log2 = 4'd1; run = 1'b1;
    tick();
    expect_out(-3, 5);
    send(-3, 5);
    send(-2, 6);
    run = 1'b0;
    tick(); tick();

    // Backpressure, drop and overrun set/clear priority
    out_ready = 1'b0; dec_log2 = 4'd2; run = 1'b1;
    tick();
    expect_out(10, 20);
    repeat (4) send(10, 20);
    check("ovr_before_drop", overrun, 0);
    repeat (4) send(50, 60);
    check("ovr_set", overrun, 1);
    check("ovr_hold_valid", out_valid, 1);
    check("ovr_hold_i", i_out, 10);
    check("ovr_hold_q", q_out, 20);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);
    repeat (3) send(1, 1);
    clear_overrun = 1'b1;
    send(1, 1);
    clear_overrun = 1'b0;
    check("ovr_set_beats_clear", overrun, 1);
    check("ovr_still_old_i", i_out, 10);
    out_ready = 1'b1;
    tick();
    run = 1'b0;
    tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;

    // Mid-window dec_log2 change with in_valid gaps
    dec_log2 = 4'd2; run = 1'b1;
    tick();
    send(1, -1);
    tick();
    send(2, -2);
    dec_log2 = 4'd3;
    send(3, -3);
    tick(); tick();
    expect_out(3, -3);
    send(6, -6);
    for (int n = 0; n < 8; n++) begin
      if (n == 7) expect_out(3, -4);
      send(n, -n);
      if (n == 2) tick();
      if (n == 3) check("k3_no_dump_at_4", out_valid, 0);
      if (n == 7) check("k3_dump_at_8", out_valid, 1);
    end
    run = 1'b0;
    tick(); tick();

    // Reset mid-window, then run dropped mid-window
    dec_log2 = 4'd2; run = 1'b1;
    tick();
    repeat (3) send(1000, 1000);
    reset = 1'b0;
    run   = 1'b0;
    #2;
    check("midrst_i_out", i_out, 0);
    check("midrst_valid", out_valid, 0);
    tick();
    reset = 1'b1;
    run   = 1'b1;
    tick();
    expect_out(4, 8);
    repeat (4) send(4, 8);
    repeat (2) send(500, 500);
    run = 1'b0;
    tick(); tick();
    check("partial_no_output", out_valid, 0);
    run = 1'b1;
    tick();
    expect_out(-4, -8);
    repeat (4) send(-4, -8);
    run = 1'b0;
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_iq_integrate_dump

// File: doc/iq_integrate_dump.md
Name: iq_integrate_dump

Overview:
Decimating integrate-and-dump stage that sits directly downstream of the I/Q comb filter in the anchor receive chain. It accumulates 2^k consecutive complex samples and emits their average (sum arithmetic-shifted right by k) as one output sample. The decimation exponent k is selectable at run time. A valid/ready handshake on the output, with a sticky overrun flag, lets slower consumers (FIFO or host interface) throttle the stream.

Parameters:
BIT_WIDTH, 16, width of I/Q input and output samples (two's complement)
DEC_LOG2_MAX, 8, largest supported decimation exponent; accumulator width is BIT_WIDTH+DEC_LOG2_MAX

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = accumulate; 0 = idle, window discarded
dec_log2  input  $clog2(DEC_LOG2_MAX+1)  decimation exponent k; window length N = 2^k
in_valid  input  1  i_in/q_in carry a sample this cycle
i_in  input  BIT_WIDTH  in-phase sample, signed
q_in  input  BIT_WIDTH  quadrature sample, signed
i_out  output  BIT_WIDTH  averaged in-phase result, signed
q_out  output  BIT_WIDTH  averaged quadrature result, signed
out_valid  output  1  i_out/q_out hold an unconsumed result
out_ready  input  1  consumer accepts the result when out_valid && out_ready
overrun  output  1  sticky: a completed result was dropped
clear_overrun  input  1  synchronous single-cycle clear of overrun

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, accumulators=0, sample counter=0, latched k=0, i_out=q_out=0, out_valid=0, overrun=0.
- States: IDLE, ACCUM.
  - IDLE -> ACCUM on the edge where run=1. On that edge, dec_log2 is latched (clamped to DEC_LOG2_MAX) and the counter and accumulators are cleared.
  - ACCUM -> IDLE on any edge where run=0. The partial window is discarded and the accumulators and counter are zeroed. A pending output is retained until consumed.
- Accepted sample: state=ACCUM && in_valid=1. Accumulators add the sign-extended input. The counter increments modulo N.
- Dump: on the accepted sample with counter==N-1.
  - sum = acc + sample, computed at full width. Result = sum >>> k (arithmetic shift, truncation toward -inf), taking the low BIT_WIDTH bits. The average of N BIT_WIDTH-bit values always fits, so no saturation is needed.
  - On the same edge: the accumulators load 0, the counter loads 0, and dec_log2 is re-latched. No sample is lost between windows.
- Latency: result is on i_out/q_out with out_valid=1 in the cycle after the edge that accepted the Nth sample. k=0 therefore gives a registered pass-through with 1-cycle latency.
- dec_log2 changes mid-window are ignored until the next dump or the next IDLE->ACCUM transition.
- Handshake:
  - i_out/q_out hold stable while out_valid=1 && out_ready=0.
  - Transfer occurs when out_valid && out_ready. out_valid falls next cycle unless a dump coincides.
- Dump coincident with out_valid=1 && out_ready=1: the new result loads and out_valid stays 1 (back-to-back).
- Dump coincident with out_valid=1 && out_ready=0: the new result is dropped, the old result is kept, and overrun is set to 1.
- overrun persists until clear_overrun=1. If a set and a clear occur on the same edge, set wins.
- in_valid=0 cycles inside a window pause accumulation; they do not end the window.
- Reset asserted mid-window or mid-handshake: all state returns to reset values immediately. Any pending output is lost.

Decomposition:
- Shared package holds:
  - ACC_WIDTH = BIT_WIDTH+DEC_LOG2_MAX
  - the DEC_LOG2_MAX-based width of dec_log2
  - the two-value state enum (IDLE, ACCUM)
- One sub-module, iq_dump_channel, instantiated twice (I and Q). It contains the accumulator, the shift, and the result register. Counter, state machine, handshake and overrun logic live in the top and are shared.

Test Plan:
- k=2, run=1, in_valid=1, constant i=100, q=-100 for 16 cycles -> 4 results of 100/-100. out_valid rises 1 cycle after each 4th sample. out_ready=1.
- k=0, ramp i=0,1,2,... -> i_out equals the input delayed 1 cycle, every cycle. out_valid held 1.
- k=8, i=-32768, q=32767 for 256 samples -> i_out=-32768, q_out=32767 (no wrap). Then k=1 with i=-3,-2 -> -3 (floor of -2.5).
- k=2, out_ready=0 across two windows -> first result held stable, second dropped, overrun=1. clear_overrun pulse -> 0. Simultaneous set and clear -> stays 1.
- k=2, change dec_log2 to 3 after 2 samples -> current window still ends after 4 samples; next window takes 8. in_valid gaps do not shift the result values.
- Assert reset after 3 of 4 samples, release, run on -> first result contains only post-reset samples. Dropping run mid-window -> no output from that partial window.
